// File: rtl/m_spi_fifo_tx_pkg.sv
// Shared definitions for the FIFO-fed SPI transmitter: FSM encoding and default parameters.
package m_spi_fifo_tx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } spi_state_e;

  localparam int unsigned DefDataW  = 8;
  localparam int unsigned DefDepth  = 16;
  localparam int unsigned DefClkDiv = 1;
  localparam int unsigned DefGapCyc = 0;
  localparam logic        DefCpol   = 1'b1;

endpackage

// File: rtl/m_sync_fifo.sv
// Single-clock FIFO with registered occupancy; full blocks pushes even on a same-cycle pop.
module m_sync_fifo
  import m_spi_fifo_tx_pkg::*;
#(
  parameter int unsigned WIDTH = DefDataW + 1,
  parameter int unsigned DEPTH = DefDepth,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             w_clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign full     = (level_q == (AW + 1)'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full && !reset;
  assign do_pop   = pop && !empty;

  always_ff @(posedge w_clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        level_q <= level_q + 1'b1;
      end else if (!do_push && do_pop) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

  always_ff @(posedge w_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/m_spi_fifo_tx.sv
// FIFO-buffered SPI transmitter: words go out MSB first with DC held per word and CS_N
// held low across back-to-back words.
module m_spi_fifo_tx
  import m_spi_fifo_tx_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned DEPTH   = DefDepth,
  parameter int unsigned CLK_DIV = DefClkDiv,
  parameter int unsigned GAP_CYC = DefGapCyc,
  parameter logic        CPOL    = DefCpol
) (
  input  logic                     w_clk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_dc,
  output logic                     SDA,
  output logic                     SCL,
  output logic                     DC,
  output logic                     CS_N,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned CntMax = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned HalfW  = $clog2(2 * DATA_W);

  spi_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [HalfW-1:0]  half_q, half_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              scl_q, scl_d;
  logic              dc_q, dc_d;
  logic              cs_n_q, cs_n_d;

  logic              fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W:0]   fifo_data;
  logic              load, word_done;

  m_sync_fifo #(
    .WIDTH(DATA_W + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .w_clk    (w_clk),
    .reset    (reset),
    .push     (s_valid),
    .push_data({s_dc, s_data}),
    .pop      (fifo_pop),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    shreg_d   = shreg_q;
    scl_d     = scl_q;
    dc_d      = dc_q;
    cs_n_d    = cs_n_q;
    fifo_pop  = 1'b0;
    load      = 1'b0;
    word_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) load = 1'b1;
      end
      StShift: begin
        if (cnt_q == CntW'(CLK_DIV - 1)) begin
          cnt_d  = '0;
          scl_d  = !scl_q;
          half_d = half_q + 1'b1;
          if (half_q == HalfW'(2 * DATA_W - 1)) begin
            if (GAP_CYC > 0) state_d = StGap;
            else             word_done = 1'b1;
          end else if (half_q[0]) begin
            // End of an odd half-period is the next bit's leading edge.
            shreg_d = shreg_q << 1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == CntW'(GAP_CYC - 1)) word_done = 1'b1;
        else                             cnt_d = cnt_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (word_done) begin
      if (!fifo_empty) begin
        load = 1'b1;
      end else begin
        state_d = StIdle;
        cs_n_d  = 1'b1;
        scl_d   = CPOL;
      end
    end

    if (load) begin
      fifo_pop = 1'b1;
      shreg_d  = fifo_data[DATA_W-1:0];
      dc_d     = fifo_data[DATA_W];
      cs_n_d   = 1'b0;
      scl_d    = CPOL;
      cnt_d    = '0;
      half_d   = '0;
      state_d  = StShift;
    end
  end

  always_ff @(posedge w_clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      half_q  <= '0;
      shreg_q <= '0;
      scl_q   <= CPOL;
      dc_q    <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      shreg_q <= shreg_d;
      scl_q   <= scl_d;
      dc_q    <= dc_d;
      cs_n_q  <= cs_n_d;
    end
  end

  assign SDA     = shreg_q[DATA_W-1];
  assign SCL     = scl_q;
  assign DC      = dc_q;
  assign CS_N    = cs_n_q;
  assign s_ready = !fifo_full;
  assign busy    = (state_q != StIdle) || !fifo_empty;

endmodule
